// File: rtl/audio_pkg.sv
// Shared definitions for the audio IN byte-stream unpacker: FSM state type,
// sync byte constant and sample-width legality check.
package audio_pkg;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_BYTES = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] AUDIO_SYNC_BYTE = 8'hA5;

    localparam int unsigned BPS_MIN = 32'd2;
    localparam int unsigned BPS_MAX = 32'd4;

    function automatic logic bps_legal(input int unsigned bps);
        return (bps >= BPS_MIN) && (bps <= BPS_MAX);
    endfunction

endpackage

// File: rtl/audio_in_unpacker.sv
// Unpacks little-endian stereo PCM frames from the IN FIFO into L/R sample pairs.
// Optional per-frame sync byte hunting is enabled by defining AUDIO_SYNC_EN.
import audio_pkg::*;

module audio_in_unpacker #(
    parameter int unsigned BYTES_PER_SAMPLE = 3,
    parameter int unsigned SAMPLE_W         = 8 * BYTES_PER_SAMPLE
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    output logic                rd_in_fifo_clk_o,
    output logic                rd_in_fifo_en_o,
    input  logic [7:0]          rd_in_fifo_data_i,
    input  logic                rd_in_fifo_empty_i,
    output logic [SAMPLE_W-1:0] sample_l_o,
    output logic [SAMPLE_W-1:0] sample_r_o,
    output logic                sample_valid_o,
    input  logic                sample_ready_i
`ifdef AUDIO_SYNC_EN
    ,
    output logic [15:0]         sync_err_count_o
`endif
);

    localparam logic [2:0] LAST_IDX = 3'(2 * BYTES_PER_SAMPLE - 1);
    localparam logic [2:0] HALF_IDX = 3'(BYTES_PER_SAMPLE);
`ifdef AUDIO_SYNC_EN
    localparam state_t ST_START = ST_SYNC;
`else
    localparam state_t ST_START = ST_BYTES;
`endif

    if (!bps_legal(BYTES_PER_SAMPLE)) begin : g_bps_illegal
        $error("audio_in_unpacker: BYTES_PER_SAMPLE must be 2..4");
    end

    state_t              state_r;
    state_t              state_next_s;
    logic [2:0]          cnt_r;
    logic [2:0]          cnt_next_s;
    logic                pend_r;
    logic [2:0]          pend_idx_r;
    logic                run_r;
    logic                rd_en_s;
    logic                free_s;
    logic                load_s;
    logic [SAMPLE_W-1:0] left_sh_r;
    logic [SAMPLE_W-1:0] right_sh_r;
    logic [SAMPLE_W-1:0] left_next_s;
    logic [SAMPLE_W-1:0] right_next_s;
    logic [SAMPLE_W-1:0] sample_l_r;
    logic [SAMPLE_W-1:0] sample_r_r;
    logic                valid_r;

    assign rd_in_fifo_clk_o = clk_i;
    assign rd_in_fifo_en_o  = rd_en_s;
    assign sample_l_o       = sample_l_r;
    assign sample_r_o       = sample_r_r;
    assign sample_valid_o   = valid_r;
    assign free_s           = ~valid_r | sample_ready_i;

    // Read request: combinational on empty so a same-edge empty never launches a read.
    always_comb begin
        rd_en_s = 1'b0;
        case (state_r)
            ST_BYTES: rd_en_s = run_r & ~rd_in_fifo_empty_i;
`ifdef AUDIO_SYNC_EN
            ST_SYNC:  rd_en_s = run_r & ~rd_in_fifo_empty_i & ~pend_r;
`endif
            default:  rd_en_s = 1'b0;
        endcase
    end

    // Shift the in-flight byte into its channel; first byte ends up as the LSB.
    always_comb begin
        left_next_s  = left_sh_r;
        right_next_s = right_sh_r;
        if (pend_r && (state_r != ST_SYNC)) begin
            if (pend_idx_r < HALF_IDX) begin
                left_next_s = {rd_in_fifo_data_i, left_sh_r[SAMPLE_W-1:8]};
            end else begin
                right_next_s = {rd_in_fifo_data_i, right_sh_r[SAMPLE_W-1:8]};
            end
        end else begin
            left_next_s  = left_sh_r;
            right_next_s = right_sh_r;
        end
    end

    // Next-state and byte counter logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        load_s       = 1'b0;
        case (state_r)
            ST_BYTES: begin
                if (rd_en_s && (cnt_r == LAST_IDX)) begin
                    state_next_s = ST_HOLD;
                end else if (rd_en_s) begin
                    cnt_next_s = cnt_r + 3'd1;
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            ST_HOLD: begin
                // Exit may coincide with the last byte arriving; next-values cover it.
                if (free_s) begin
                    load_s       = 1'b1;
                    cnt_next_s   = 3'd0;
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
`ifdef AUDIO_SYNC_EN
            ST_SYNC: begin
                if (pend_r && (rd_in_fifo_data_i == AUDIO_SYNC_BYTE)) begin
                    state_next_s = ST_BYTES;
                end else begin
                    state_next_s = ST_SYNC;
                end
            end
`endif
            default: begin
                state_next_s = ST_START;
                cnt_next_s   = 3'd0;
            end
        endcase
    end

    // Control state: FSM, counter, in-flight capture tracking.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= ST_START;
            cnt_r      <= 3'd0;
            pend_r     <= 1'b0;
            pend_idx_r <= 3'd0;
            run_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            pend_r     <= rd_en_s;
            pend_idx_r <= cnt_r;
            run_r      <= 1'b1;
        end
    end

    // Channel shift registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            left_sh_r  <= {SAMPLE_W{1'b0}};
            right_sh_r <= {SAMPLE_W{1'b0}};
        end else begin
            left_sh_r  <= left_next_s;
            right_sh_r <= right_next_s;
        end
    end

    // Output holding register and valid/ready handshake.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sample_l_r <= {SAMPLE_W{1'b0}};
            sample_r_r <= {SAMPLE_W{1'b0}};
            valid_r    <= 1'b0;
        end else if (load_s) begin
            sample_l_r <= left_next_s;
            sample_r_r <= right_next_s;
            valid_r    <= 1'b1;
        end else if (valid_r && sample_ready_i) begin
            valid_r    <= 1'b0;
        end
    end

`ifdef AUDIO_SYNC_EN
    logic [15:0] sync_err_r;
    assign sync_err_count_o = sync_err_r;

    // Saturating count of bytes discarded while hunting for sync.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_err_r <= 16'd0;
        end else if ((state_r == ST_SYNC) && pend_r &&
                     (rd_in_fifo_data_i != AUDIO_SYNC_BYTE) && (sync_err_r != 16'hFFFF)) begin
            sync_err_r <= sync_err_r + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_audio_in_unpacker.sv
// Directed self-checking bench for audio_in_unpacker (BYTES_PER_SAMPLE=3),
// with a behavioural IN FIFO that has one-cycle registered read latency.
module tb_audio_in_unpacker;

    localparam int BPS = 3;
    localparam int SW  = 8 * BPS;
    localparam int FB  = 2 * BPS;
`ifdef AUDIO_SYNC_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int PERIOD = FB + 1 + 2 * HDR;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rd_clk;
    logic          rd_en;
    logic [7:0]    rd_data = 8'h00;
    logic          fifo_empty = 1'b1;
    logic [SW-1:0] sl;
    logic [SW-1:0] sr;
    logic          sv;
    logic          ready = 1'b0;
`ifdef AUDIO_SYNC_EN
    logic [15:0]   err_cnt;
`endif

    logic [7:0]      fifo_q[$];
    logic [2*SW-1:0] out_q[$];
    int              out_cyc_q[$];
    int cyc = 0;
    int reads = 0;
    int last_pop_cyc = 0;
    int viol = 0;
    int valid_cycles = 0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    audio_in_unpacker #(.BYTES_PER_SAMPLE(BPS)) dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .rd_in_fifo_clk_o   (rd_clk),
        .rd_in_fifo_en_o    (rd_en),
        .rd_in_fifo_data_i  (rd_data),
        .rd_in_fifo_empty_i (fifo_empty),
        .sample_l_o         (sl),
        .sample_r_o         (sr),
        .sample_valid_o     (sv),
        .sample_ready_i     (ready)
`ifdef AUDIO_SYNC_EN
        ,
        .sync_err_count_o   (err_cnt)
`endif
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en && !fifo_empty) begin
            rd_data      <= fifo_q.pop_front();
            reads        <= reads + 1;
            last_pop_cyc <= cyc + 1;
            fifo_empty   <= (fifo_q.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (rd_en && fifo_empty) viol++;
        if (sv) valid_cycles++;
        if (sv && ready) begin
            out_q.push_back({sl, sr});
            out_cyc_q.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic push_hdr();
`ifdef AUDIO_SYNC_EN
        push_byte(8'hA5);
`endif
    endtask

    task automatic push_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
        push_hdr();
        for (int i = 0; i < BPS; i++) push_byte(l[8*i +: 8]);
        for (int i = 0; i < BPS; i++) push_byte(r[8*i +: 8]);
    endtask

    task automatic clear_out();
        out_q.delete();
        out_cyc_q.delete();
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int k = 0;
        while (out_q.size() < n && k < budget) begin
            step(1);
            k++;
        end
        vectors++;
        if (out_q.size() < n) begin
            miscompares++;
            $display("FAIL %s timeout: got %0d frames, need %0d", name, out_q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(3);
        vectors++;
        if ({rd_en, sv, sl, sr} !== {2'b00, {(2*SW){1'b0}}}) begin
            miscompares++;
            $display("FAIL reset_outputs: en=%b valid=%b l=%h r=%h, need all 0", rd_en, sv, sl, sr);
        end
`ifdef AUDIO_SYNC_EN
        vectors++;
        if (err_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_err_cnt: got %h need 0000", err_cnt);
        end
`endif
        vectors++;
        if (rd_clk !== clk) begin
            miscompares++;
            $display("FAIL rd_clk: got %b need %b", rd_clk, clk);
        end
        reset_n = 1'b1;
        step(2);
        vectors++;
        if ({rd_en, sv} !== 2'b00) begin
            miscompares++;
            $display("FAIL post_reset_idle: en=%b valid=%b, need 0 0", rd_en, sv);
        end
    endtask

    task automatic test_single_frame();
        int base = reads;
        int vbase;
        ready = 1'b1;
        clear_out();
        vbase = valid_cycles;
        push_hdr();
        for (int i = 1; i <= FB; i++) push_byte(8'(i));
        wait_frames(1, 40, "single_frame");
        step(5);
        if (out_q.size() >= 1) begin
            vectors++;
            if (out_q[0] !== {24'h030201, 24'h060504}) begin
                miscompares++;
                $display("FAIL single_data: got %h need 030201060504", out_q[0]);
            end
            vectors++;
            if (out_cyc_q[0] - last_pop_cyc !== 1) begin
                miscompares++;
                $display("FAIL single_latency: valid %0d edges after last read, need 1", out_cyc_q[0] - last_pop_cyc);
            end
        end
        vectors++;
        if (valid_cycles - vbase !== 1) begin
            miscompares++;
            $display("FAIL single_valid_width: got %0d cycles need 1", valid_cycles - vbase);
        end
        vectors++;
        if (reads - base !== FB + HDR) begin
            miscompares++;
            $display("FAIL single_reads: got %0d need %0d", reads - base, FB + HDR);
        end
    endtask

    task automatic test_back_to_back();
        logic [SW-1:0] exp_l[4] = '{24'h112233, 24'hA5A5A5, 24'h000000, 24'hFFEE01};
        logic [SW-1:0] exp_r[4] = '{24'h445566, 24'h5A5A5A, 24'h800001, 24'h7F0080};
        ready = 1'b1;
        clear_out();
        for (int i = 0; i < 4; i++) push_frame(exp_l[i], exp_r[i]);
        wait_frames(4, 120, "b2b_frames");
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            vectors++;
            if (out_q[i] !== {exp_l[i], exp_r[i]}) begin
                miscompares++;
                $display("FAIL b2b_data[%0d]: got %h need %h", i, out_q[i], {exp_l[i], exp_r[i]});
            end
            if (i > 0) begin
                vectors++;
                if (out_cyc_q[i] - out_cyc_q[i-1] !== PERIOD) begin
                    miscompares++;
                    $display("FAIL b2b_spacing[%0d]: got %0d need %0d", i, out_cyc_q[i] - out_cyc_q[i-1], PERIOD);
                end
            end
        end
        vectors++;
        if (viol !== 0) begin
            miscompares++;
            $display("FAIL en_while_empty: got %0d cycles need 0", viol);
        end
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] exp_l[3] = '{24'h0A0B0C, 24'h102030, 24'hC0FFEE};
        logic [SW-1:0] exp_r[3] = '{24'h0D0E0F, 24'h405060, 24'hBADF00};
        int base = reads;
        ready = 1'b0;
        clear_out();
        for (int i = 0; i < 3; i++) push_frame(exp_l[i], exp_r[i]);
        step(60);
        vectors++;
        if (reads - base !== 2 * (FB + HDR)) begin
            miscompares++;
            $display("FAIL bp_reads: got %0d need %0d", reads - base, 2 * (FB + HDR));
        end
        vectors++;
        if ({rd_en, sv, sl, sr} !== {2'b01, exp_l[0], exp_r[0]}) begin
            miscompares++;
            $display("FAIL bp_hold: en=%b valid=%b l=%h r=%h, need en=0 valid=1 l=%h r=%h",
                     rd_en, sv, sl, sr, exp_l[0], exp_r[0]);
        end
        step(10);
        vectors++;
        if ({sv, sl, sr, 32'(reads - base)} !== {1'b1, exp_l[0], exp_r[0], 32'(2 * (FB + HDR))}) begin
            miscompares++;
            $display("FAIL bp_stable: valid=%b l=%h r=%h reads=%0d", sv, sl, sr, reads - base);
        end
        ready = 1'b1;
        wait_frames(3, 80, "bp_release");
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            vectors++;
            if (out_q[i] !== {exp_l[i], exp_r[i]}) begin
                miscompares++;
                $display("FAIL bp_order[%0d]: got %h need %h", i, out_q[i], {exp_l[i], exp_r[i]});
            end
        end
    endtask

    task automatic test_empty_gap();
        int base = reads;
        ready = 1'b1;
        clear_out();
        push_hdr();
        push_byte(8'h21); push_byte(8'h43); push_byte(8'h65); push_byte(8'h87);
        step(12);
        vectors++;
        if (out_q.size() !== 0 || reads - base !== 4 + HDR) begin
            miscompares++;
            $display("FAIL gap_pause: frames=%0d reads=%0d, need 0 and %0d", out_q.size(), reads - base, 4 + HDR);
        end
        push_byte(8'hA9); push_byte(8'hCB);
        wait_frames(1, 30, "gap_frame");
        step(10);
        vectors++;
        if (out_q.size() !== 1 || out_q[0] !== {24'h654321, 24'hCBA987}) begin
            miscompares++;
            $display("FAIL gap_data: frames=%0d first=%h need 1 frame 654321cba987",
                     out_q.size(), out_q.size() > 0 ? out_q[0] : 48'h0);
        end
        vectors++;
        if (reads - base !== FB + HDR) begin
            miscompares++;
            $display("FAIL gap_reads: got %0d need %0d", reads - base, FB + HDR);
        end
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        clear_out();
        push_frame(24'h111111, 24'h222222);
        step(15);
        vectors++;
        if (sv !== 1'b1) begin
            miscompares++;
            $display("FAIL rm_held: valid=%b need 1", sv);
        end
        push_hdr();
        push_byte(8'hDE); push_byte(8'hAD); push_byte(8'hBE);
        step(8);
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({rd_en, sv, sl, sr} !== {2'b00, {(2*SW){1'b0}}}) begin
            miscompares++;
            $display("FAIL rm_reset_outputs: en=%b valid=%b l=%h r=%h, need all 0", rd_en, sv, sl, sr);
        end
        step(2);
        reset_n = 1'b1;
        ready = 1'b1;
        step(1);
        push_frame(24'h563412, 24'hBC9A78);
        wait_frames(1, 40, "rm_frame");
        step(10);
        vectors++;
        if (out_q.size() !== 1 || out_q[0] !== {24'h563412, 24'hBC9A78}) begin
            miscompares++;
            $display("FAIL rm_data: frames=%0d first=%h need 1 frame 563412bc9a78",
                     out_q.size(), out_q.size() > 0 ? out_q[0] : 48'h0);
        end
    endtask

`ifdef AUDIO_SYNC_EN
    task automatic test_sync();
        ready = 1'b1;
        clear_out();
        push_byte(8'h11); push_byte(8'h22); push_byte(8'hA5);
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
        push_byte(8'h04); push_byte(8'h05); push_byte(8'h06);
        wait_frames(1, 40, "sync_frame");
        step(5);
        vectors++;
        if (err_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL sync_err_cnt: got %0d need 2", err_cnt);
        end
        vectors++;
        if (out_q.size() !== 1 || out_q[0] !== {24'h030201, 24'h060504}) begin
            miscompares++;
            $display("FAIL sync_data: frames=%0d first=%h need 1 frame 030201060504",
                     out_q.size(), out_q.size() > 0 ? out_q[0] : 48'h0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_empty_gap();
        test_reset_mid();
`ifdef AUDIO_SYNC_EN
        test_sync();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
